// File: rtl/eth_bus_seq.sv
// Strobed command/address/data bus sequencer for an external Ethernet MAC register port.
// Each command runs an optional address phase and then one data phase on a shared tristate bus.
module eth_bus_seq #(
    parameter int DW     = 16,
    parameter int STROBE = 2,
    parameter int RECOV  = 1
) (
    input  logic          clk40m,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic          cmd_burst,
    input  logic          cmd_word,
    input  logic [7:0]    cmd_offset,
    input  logic [DW-1:0] cmd_wdata,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          err,
    output logic          busy,
    output logic          CMD,
    output logic          RDN,
    output logic          WRN,
    inout  wire  [DW-1:0] SD
);

    localparam int MAXPH = (STROBE > RECOV) ? STROBE : RECOV;
    localparam int CW    = $clog2(MAXPH + 1);
    localparam logic [CW-1:0] STB_L = CW'(STROBE);
    localparam logic [CW-1:0] REC_L = CW'(RECOV);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_REC, DATA, DATA_REC} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last, accept, reject, new_addr;
    logic          done_n, err_n;

    logic          wr_q, wr_n;
    logic          addr_vld;
    logic [DW-1:0] addr_q, addr_n, wdata_q, wdata_n, addr_new;
    logic [3:0]    be;

    logic          cmd_q, rdn_q, wrn_q, sd_oe;
    logic [DW-1:0] sd_out;
    logic          cmd_d, rdn_d, wrn_d, sd_oe_d;
    logic [DW-1:0] sd_out_d;

    // Byte enables live in the top nibble of the address word.
    always_comb begin
        be = 4'b0000;
        if (cmd_word)
            be = cmd_offset[1] ? 4'b1100 : 4'b0011;
        else
            be[cmd_offset[1:0]] = 1'b1;
    end

    assign addr_new = DW'({be, 4'b0000, cmd_offset});

    assign last      = (cnt == ONE);
    assign cmd_ready = (state == IDLE) || (state == DATA_REC && last);
    assign accept    = cmd_valid && cmd_ready;
    assign reject    = cmd_word && cmd_offset[0];
    assign new_addr  = !(cmd_burst && addr_vld);

    // Phase sequencing; a command accepted in the final recovery cycle overrides the return to IDLE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            ADDR: begin
                if (last) begin
                    state_n = ADDR_REC;
                    cnt_n   = REC_L;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            ADDR_REC: begin
                if (last) begin
                    state_n = DATA;
                    cnt_n   = STB_L;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            DATA: begin
                if (last) begin
                    state_n = DATA_REC;
                    cnt_n   = REC_L;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            DATA_REC: begin
                if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            if (reject) begin
                state_n = IDLE;
                done_n  = 1'b1;
                err_n   = 1'b1;
            end else begin
                state_n = new_addr ? ADDR : DATA;
                cnt_n   = STB_L;
            end
        end
    end

    // Command fields as they will be once this edge's accept has latched them.
    always_comb begin
        wr_n    = wr_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        if (accept && !reject) begin
            wr_n    = cmd_wr;
            wdata_n = cmd_wdata;
            if (new_addr)
                addr_n = addr_new;
        end
    end

    // Bus pins are registered from the next state so strobes never glitch.
    always_comb begin
        cmd_d    = (state_n == IDLE) || (state_n == ADDR) || (state_n == ADDR_REC);
        wrn_d    = !((state_n == ADDR) || (state_n == DATA && wr_n));
        rdn_d    = !(state_n == DATA && !wr_n);
        sd_oe_d  = (state_n == ADDR) || (state_n == ADDR_REC) ||
                   (((state_n == DATA) || (state_n == DATA_REC)) && wr_n);
        sd_out_d = ((state_n == ADDR) || (state_n == ADDR_REC)) ? addr_n : wdata_n;
    end

    always_ff @(posedge clk40m or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            addr_vld <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rd_data  <= '0;
            cmd_q    <= 1'b1;
            rdn_q    <= 1'b1;
            wrn_q    <= 1'b1;
            sd_oe    <= 1'b0;
            sd_out   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            wr_q    <= wr_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            done    <= done_n;
            err     <= err_n;
            cmd_q   <= cmd_d;
            rdn_q   <= rdn_d;
            wrn_q   <= wrn_d;
            sd_oe   <= sd_oe_d;
            sd_out  <= sd_out_d;
            if (accept && !reject && new_addr)
                addr_vld <= 1'b1;
            // Device data is sampled at the edge that ends the read strobe.
            if (state == DATA && !wr_q && last)
                rd_data <= SD;
        end
    end

    assign busy = (state != IDLE);
    assign CMD  = cmd_q;
    assign RDN  = rdn_q;
    assign WRN  = wrn_q;
    assign SD   = sd_oe ? sd_out : {DW{1'bz}};

endmodule

// File: tb/tb_eth_bus_seq.sv
// Directed bench for eth_bus_seq: default timing instance plus a STROBE=4/RECOV=2 instance.
`timescale 1ns/1ps
module tb_eth_bus_seq;

    logic clk40m = 1'b0;
    logic reset  = 1'b0;
    always #10 clk40m = ~clk40m;

    logic        cmd_valid = 1'b0, cmd_wr = 1'b0, cmd_burst = 1'b0, cmd_word = 1'b0;
    logic [7:0]  cmd_offset = 8'h00;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        cmd_ready, done, err, busy, CMD, RDN, WRN;
    logic [15:0] rd_data;
    wire  [15:0] SD;

    // Device model: drives read data while RDN is low; probe forces a known value to expose DUT drive.
    logic        dev_en = 1'b0, probe_en = 1'b1;
    logic [15:0] dev_d = 16'h0000;
    assign SD = (probe_en || (dev_en && !RDN)) ? dev_d : 16'hzzzz;

    logic        c2_valid = 1'b0;
    logic        c2_ready, done2, err2, busy2, CMD2, RDN2, WRN2;
    logic [15:0] rd_data2;
    wire  [15:0] SD2;

    eth_bus_seq #(.DW(16), .STROBE(2), .RECOV(1)) u_dut (
        .clk40m(clk40m), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_burst(cmd_burst),
        .cmd_word(cmd_word), .cmd_offset(cmd_offset), .cmd_wdata(cmd_wdata),
        .rd_data(rd_data), .done(done), .err(err), .busy(busy),
        .CMD(CMD), .RDN(RDN), .WRN(WRN), .SD(SD)
    );

    eth_bus_seq #(.DW(16), .STROBE(4), .RECOV(2)) u_dut2 (
        .clk40m(clk40m), .reset(reset),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_wr(1'b1), .cmd_burst(1'b0),
        .cmd_word(1'b1), .cmd_offset(8'h10), .cmd_wdata(16'hA5A5),
        .rd_data(rd_data2), .done(done2), .err(err2), .busy(busy2),
        .CMD(CMD2), .RDN(RDN2), .WRN(WRN2), .SD(SD2)
    );

    // Control patterns {CMD,RDN,WRN,done,err,busy}
    localparam logic [5:0] P_A   = 6'b110001;
    localparam logic [5:0] P_AR  = 6'b111001;
    localparam logic [5:0] P_DW  = 6'b010001;
    localparam logic [5:0] P_DR  = 6'b001001;
    localparam logic [5:0] P_RC  = 6'b011001;
    localparam logic [5:0] P_DN  = 6'b111100;
    localparam logic [5:0] P_IDL = 6'b111000;
    localparam logic [5:0] P_ER  = 6'b111110;
    localparam logic [5:0] P_DNR = 6'b001101;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic cyc(input string tag, input int k, input logic [5:0] ectl,
                       input logic [15:0] esd, input bit sd_care);
        @(negedge clk40m);
        chk($sformatf("%s_k%0d", tag, k), {26'd0, CMD, RDN, WRN, done, err, busy}, {26'd0, ectl});
        if (sd_care)
            chk($sformatf("%s_k%0d_sd", tag, k), {16'd0, SD}, {16'd0, esd});
    endtask

    task automatic issue(input bit wr, input bit burst, input bit word,
                         input logic [7:0] off, input logic [15:0] wd);
        @(negedge clk40m);
        cmd_valid  = 1'b1;
        cmd_wr     = wr;
        cmd_burst  = burst;
        cmd_word   = word;
        cmd_offset = off;
        cmd_wdata  = wd;
        chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Drop valid and scramble the command fields, which must be ignored after accept.
    task automatic drop_cmd();
        cmd_valid  = 1'b0;
        cmd_wdata  = 16'h1111;
        cmd_offset = 8'hFF;
        cmd_wr     = ~cmd_wr;
    endtask

    logic [12:0] wrn_v, done_v, cmd_v;

    initial begin
        // Reset state
        repeat (2) @(negedge clk40m);
        chk("rst_ctl", {26'd0, CMD, RDN, WRN, done, err, busy}, {26'd0, P_IDL});
        chk("rst_rd_data", {16'd0, rd_data}, 32'h0);
        chk("rst_sd_release", {16'd0, SD}, 32'h0);
        chk("rst_ready2", {31'd0, c2_ready}, 32'd1);
        reset    = 1'b1;
        probe_en = 1'b0;

        // Word write 0x10 / 0xBEEF
        issue(1'b1, 1'b0, 1'b1, 8'h10, 16'hBEEF);
        cyc("wr", 1, P_A, 16'h3010, 1'b1);
        drop_cmd();
        cyc("wr", 2, P_A, 16'h3010, 1'b1);
        cyc("wr", 3, P_AR, 16'h3010, 1'b1);
        chk("wr_ready_mid", {31'd0, cmd_ready}, 32'd0);
        cyc("wr", 4, P_DW, 16'hBEEF, 1'b1);
        cyc("wr", 5, P_DW, 16'hBEEF, 1'b1);
        cyc("wr", 6, P_RC, 16'hBEEF, 1'b1);
        cyc("wr", 7, P_DN, 16'h0, 1'b0);

        // Byte read 0x23, device returns 0x5A00
        dev_en = 1'b1;
        dev_d  = 16'h5A00;
        issue(1'b0, 1'b0, 1'b0, 8'h23, 16'h0);
        cyc("rd", 1, P_A, 16'h8023, 1'b1);
        drop_cmd();
        cyc("rd", 2, P_A, 16'h8023, 1'b1);
        cyc("rd", 3, P_AR, 16'h8023, 1'b1);
        cyc("rd", 4, P_DR, 16'h5A00, 1'b1);
        cyc("rd", 5, P_DR, 16'h5A00, 1'b1);
        cyc("rd", 6, P_RC, 16'h0, 1'b0);
        cyc("rd", 7, P_DN, 16'h0, 1'b0);
        chk("rd_data", {16'd0, rd_data}, 32'h5A00);

        // Read, then a burst read held valid: accepted in the final recovery cycle
        issue(1'b0, 1'b0, 1'b0, 8'h23, 16'h0);
        cyc("br", 1, P_A, 16'h8023, 1'b1);
        cmd_burst = 1'b1;
        chk("br_ready_k1", {31'd0, cmd_ready}, 32'd0);
        cyc("br", 2, P_A, 16'h8023, 1'b1);
        cyc("br", 3, P_AR, 16'h8023, 1'b1);
        cyc("br", 4, P_DR, 16'h5A00, 1'b1);
        cyc("br", 5, P_DR, 16'h5A00, 1'b1);
        cyc("br", 6, P_RC, 16'h0, 1'b0);
        chk("br_ready_k6", {31'd0, cmd_ready}, 32'd1);
        chk("br_rd_first", {16'd0, rd_data}, 32'h5A00);
        dev_d = 16'h1234;
        cyc("br", 7, P_DNR, 16'h1234, 1'b1);
        drop_cmd();
        cmd_burst = 1'b0;
        cyc("br", 8, P_DR, 16'h1234, 1'b1);
        cyc("br", 9, P_RC, 16'h0, 1'b0);
        cyc("br", 10, P_DN, 16'h0, 1'b0);
        chk("br_rd_second", {16'd0, rd_data}, 32'h1234);

        // Misaligned word command is rejected with no bus activity
        issue(1'b1, 1'b0, 1'b1, 8'h11, 16'hDEAD);
        cyc("rej", 1, P_ER, 16'h0, 1'b0);
        drop_cmd();
        cyc("rej", 2, P_IDL, 16'h0, 1'b0);

        // Reset during the write data phase, then a burst write must still take the address phase
        dev_en = 1'b0;
        issue(1'b1, 1'b0, 1'b1, 8'h10, 16'hBEEF);
        cyc("rw", 1, P_A, 16'h3010, 1'b1);
        drop_cmd();
        cyc("rw", 2, P_A, 16'h3010, 1'b1);
        cyc("rw", 3, P_AR, 16'h3010, 1'b1);
        cyc("rw", 4, P_DW, 16'hBEEF, 1'b1);
        #2;
        reset    = 1'b0;
        dev_d    = 16'h0000;
        probe_en = 1'b1;
        #1;
        chk("rw_rst_ctl", {26'd0, CMD, RDN, WRN, done, err, busy}, {26'd0, P_IDL});
        chk("rw_rst_sd", {16'd0, SD}, 32'h0);
        chk("rw_rst_rd_data", {16'd0, rd_data}, 32'h0);
        @(negedge clk40m);
        reset    = 1'b1;
        probe_en = 1'b0;
        issue(1'b1, 1'b1, 1'b1, 8'h12, 16'h0F0F);
        cyc("bw", 1, P_A, 16'hC012, 1'b1);
        drop_cmd();
        cyc("bw", 2, P_A, 16'hC012, 1'b1);
        cyc("bw", 3, P_AR, 16'hC012, 1'b1);
        cyc("bw", 4, P_DW, 16'h0F0F, 1'b1);
        cyc("bw", 5, P_DW, 16'h0F0F, 1'b1);
        cyc("bw", 6, P_RC, 16'h0F0F, 1'b1);
        cyc("bw", 7, P_DN, 16'h0, 1'b0);

        // STROBE=4 / RECOV=2 word write timing
        @(negedge clk40m);
        c2_valid = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk40m);
            c2_valid    = 1'b0;
            wrn_v[k-1]  = WRN2;
            done_v[k-1] = done2;
            cmd_v[k-1]  = CMD2;
            if (k == 1) begin
                chk("s4_sd_addr", {16'd0, SD2}, 32'h3010);
                chk("s4_busy", {31'd0, busy2}, 32'd1);
            end
            if (k == 7)
                chk("s4_sd_data", {16'd0, SD2}, 32'hA5A5);
        end
        chk("s4_wrn_trace", {19'd0, wrn_v}, 32'h1C30);
        chk("s4_done_trace", {19'd0, done_v}, 32'h1000);
        chk("s4_cmd_trace", {19'd0, cmd_v}, 32'h103F);
        chk("s4_err_rd", {15'd0, err2, rd_data2}, 32'h0);
        chk("s4_rdn", {31'd0, RDN2}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/eth_bus_seq.md
ETH_BUS_SEQ -- requirements
Module: eth_bus_seq

Interface
REQ-001 SHALL have parameter DW, 16, external data bus width (even; byte enables cover DW/8 lanes, 16 only in this revision).
REQ-002 SHALL have parameter STROBE, 2, cycles RDN/WRN held low per phase (>=1).
REQ-003 SHALL have parameter RECOV, 1, cycles strobe held high after each phase (>=1).
REQ-004 SHALL have ports:
- clk40m  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
- cmd_wr  in  1  1=write, 0=read
- cmd_burst  in  1  1=skip address phase (reuse latched address)
- cmd_word  in  1  0=byte, 1=word
- cmd_offset  in  8  register offset
- cmd_wdata  in  DW  write data
- rd_data  out  DW  last read data
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done on rejected command
- busy  out  1  high whenever state != IDLE
- CMD  out  1  bus command/data select (1=address)
- RDN  out  1  read strobe, active low
- WRN  out  1  write strobe, active low
- SD  inout  DW  shared bus; driven only when sd_oe internal is 1

Function
REQ-005 SHALL implement states IDLE, ADDR, ADDR_REC, DATA, DATA_REC.
REQ-006 SHALL assert cmd_ready in IDLE and in the final RECOV cycle of DATA_REC; low otherwise.
REQ-007 SHALL on accept with cmd_burst=0 (or no address latched since reset) go to ADDR; with cmd_burst=1 and address latched go to DATA.
REQ-008 SHALL form address word: [15:12] byte enables, [11:8]=0, [7:2]=offset[7:2], [1:0]=offset[1:0].
REQ-009 SHALL set byte enables: byte, offset[1:0]=n -> bit 12+n only; word, offset[1:0]=0 -> 12,13; word, offset[1:0]=2 -> 14,15.
REQ-010 SHALL reject word commands with offset[0]=1: accepted, no bus activity, done=err=1 next cycle, state stays IDLE.
REQ-011 ADDR: CMD=1, WRN=0, SD driven with address for STROBE cycles; ADDR_REC: WRN=1, SD still driven, RECOV cycles.
REQ-012 DATA write: CMD=0, WRN=0, SD driven with cmd_wdata (registered at accept) for STROBE cycles.
REQ-013 DATA read: CMD=0, RDN=0, SD high-Z from first DATA cycle; rd_data <= SD at posedge ending last STROBE cycle.
REQ-014 DATA_REC: RDN=WRN=1, CMD=0; SD released for reads, held for writes; RECOV cycles.
REQ-015 SHALL pulse done in cycle after last DATA_REC cycle; next state IDLE or, if new command accepted, ADDR/DATA with no idle gap.
REQ-016 Single full command latency accept-edge to done: STROBE+RECOV+STROBE+RECOV+1 cycles (7 at defaults); burst: STROBE+RECOV+1 (4).
REQ-017 SHALL never assert RDN and WRN low together; SD SHALL never drive while RDN=0.
REQ-018 cmd_* inputs SHALL be ignored except at accept; latched values held for the whole command.
REQ-019 Phase counters SHALL be ceil(log2(max(STROBE,RECOV)+1)) bits, load on phase entry, count down to 1.

Reset
REQ-020 reset low SHALL asynchronously force: state IDLE, CMD=1, RDN=1, WRN=1, SD high-Z, rd_data=0, done=0, err=0, busy=0, address-latched flag=0.
REQ-021 reset mid-phase SHALL abort without completing done; first command after release SHALL take full address phase even if cmd_burst=1.

Verification
REQ-022 Word write offset 0x10, data 0xBEEF -> SD=0x3010 with CMD=1, WRN low 2 cycles; then SD=0xBEEF, CMD=0, WRN low 2 cycles; done 7 cycles after accept.
REQ-023 Byte read offset 0x23, device drives 0x5A00 -> address SD=0x8023; RDN low 2 cycles, SD high-Z; rd_data=0x5A00 at done.
REQ-024 Read followed by cmd_burst=1 read held valid -> second accepted in final DATA_REC cycle, no ADDR phase, done 4 cycles later.
REQ-025 Word command offset 0x11 -> no strobe toggles, done=err=1 one cycle after accept, busy stays 0.
REQ-026 reset asserted during write DATA phase -> WRN=1, SD high-Z immediately; subsequent burst write performs address phase.
REQ-027 STROBE=4, RECOV=2 build, word write -> WRN low exactly 4 cycles per phase, done 13 cycles after accept.
